joypad_event_queue: RTL
=======================

# joypad_event_queue

Downstream consumer of the SNES joypad controller. Samples the 12-bit decoded button vector once per poll frame, debounces each button over consecutive frames, and turns every debounced press or release into a 5-bit event pushed into a small FIFO. Game/CPU logic reads the FIFO with a valid/ready handshake and also reads the debounced button levels directly.

## Interface

- DEBOUNCE, 2: consecutive differing samples required to flip a button; legal range 1..15.
- ADDR_W, 3: FIFO address width; depth = 2**ADDR_W (8).

- clk  in  1  system clock, same clock as the joypad controller.
- res  in  1  reset, asynchronous, active-low.
- latch  in  1  controller latch output; its rising edge is the sample strobe.
- button_data  in  12  controller button vector (0..11: up, down, left, right, A, B, X, Y, L, R, select, start).
- clr_ovf  in  1  clears overflow.
- ev_ready  in  1  consumer accepts the head event.
- ev_valid  out  1  FIFO not empty.
- ev_data  out  5  {pressed, index[3:0]} of the head event; 0 when ev_valid low.
- buttons  out  12  debounced button levels, 1 = pressed.
- ev_count  out  ADDR_W+1  FIFO occupancy.
- overflow  out  1  sticky: an event was dropped.

## Operation

- Strobe: latch high now, registered latch low last cycle. Held latch yields one strobe.
- On strobe, per button i: if button_data[i] == buttons[i], cnt[i] <= 0. Otherwise, if cnt[i] == DEBOUNCE-1, then buttons[i] <= button_data[i], cnt[i] <= 0, pend[i] <= 1; else cnt[i] <= cnt[i]+1. Counters are 4 bits.
- Scanner FSM, states IDLE and SCAN, with a 4-bit idx:
  - IDLE -> SCAN when pend != 0; idx <= 0.
  - In SCAN, each cycle examines idx. If pend[idx] is set, it pushes {buttons[idx], idx} and clears pend[idx].
  - A strobe setting pend[idx] in the same cycle wins: the bit stays set.
  - idx increments each cycle. After idx 11 the FSM returns to IDLE and re-enters SCAN next cycle if any pend bit remains.
- Events leave in ascending index order within a scan. The polarity of each event is the debounced level at push time.
- FIFO:
  - Push is accepted if count < depth, or if a pop occurs the same cycle.
  - Otherwise the event is dropped and overflow <= 1.
  - Pop when ev_valid && ev_ready.
  - Pointers wrap modulo depth.
  - Count is unchanged on simultaneous push+pop.
- overflow: clr_ovf clears it. If clr_ovf and a drop happen in the same cycle, the set wins.

## Timing

- Reset (res low, asynchronous): buttons=0, cnt=0, pend=0, FSM IDLE, idx=0, FIFO empty, ev_valid=0, ev_data=0, ev_count=0, overflow=0, registered latch=0.
- Reset asserted mid-scan aborts the scan immediately; no partial events survive.
- Strobe at edge T: buttons and pend update at T+1, and SCAN begins at T+1.
  - idx i is examined in cycle T+1+i.
  - With an empty FIFO, the event for button i shows ev_valid=1 after edge T+2+i.
- The scan is 12 cycles, far below the ~1390-cycle poll period. A strobe during SCAN still updates debounce state immediately; the new pend bits are picked up in the current scan (idx not yet reached) or in the following scan.
- The head event is stable while ev_valid && !ev_ready.
- ev_count updates the cycle after a push or pop.

## Test plan

- Reset: hold res=0 with toggling inputs -> buttons=0x000, ev_valid=0, ev_count=0, overflow=0. Release -> no events.
- Press A, DEBOUNCE=2: two strobes with button_data=0x010 -> no event after the first strobe. After the second: buttons=0x010, ev_data=5'h14, ev_valid at T+6; pop -> ev_count=0.
- Glitch rejection: strobes with 0x010, then 0x000, then 0x010 -> no event, buttons stays 0x000; cnt[4] returns to 0 after the second strobe.
- Multi-release: buttons settled at 0xFFF, then 0x7FE held for two strobes -> exactly two events, 5'h00 then 5'h0B; buttons=0x7FE.
- Overflow: ev_ready=0, generate 9 events -> ev_count=8, overflow=1, 9th event dropped. Pulse clr_ovf -> overflow=0. At full, push with ev_ready=1 in the same cycle -> push accepted, ev_count stays 8.
- Async reset mid-scan: pend=0x0F0, assert res at idx=5 -> all outputs return to reset values within the cycle; no events after release.

Source files
------------

// File: rtl/joypad_event_queue.sv
// Debounces the 12-bit joypad button vector on each latch strobe and queues
// every debounced press/release as a 5-bit {pressed, index} event in a small FIFO.
module joypad_event_queue #(
    parameter int DEBOUNCE = 2,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              res,
    input  logic              latch,
    input  logic [11:0]       button_data,
    input  logic              clr_ovf,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [4:0]        ev_data,
    output logic [11:0]       buttons,
    output logic [ADDR_W:0]   ev_count,
    output logic              overflow
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [3:0]      CNT_MAX  = 4'(DEBOUNCE - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    logic                    r_latch;
    logic                    w_strobe;
    logic [11:0]             r_buttons;
    logic [11:0][3:0]        r_cnt;
    logic [11:0]             r_pend;
    logic [11:0]             w_pend_nxt;
    logic [11:0]             w_flip;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_idx, w_idx_nxt;
    logic                    w_push;
    logic [4:0]              w_push_data;

    logic [4:0]              r_mem [DEPTH];
    logic [ADDR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]         r_count;
    logic                    r_ovf;
    logic                    w_pop, w_full, w_accept, w_drop;

    assign w_strobe = latch & ~r_latch;

    always_ff @(posedge clk or negedge res) begin
        if (!res) r_latch <= 1'b0;
        else      r_latch <= latch;
    end

    // A button flips only after DEBOUNCE consecutive differing samples.
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < 12; i++)
            w_flip[i] = w_strobe && (button_data[i] != r_buttons[i]) && (r_cnt[i] == CNT_MAX);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_buttons <= '0;
            r_cnt     <= '0;
        end else if (w_strobe) begin
            for (int i = 0; i < 12; i++) begin
                if (button_data[i] == r_buttons[i]) begin
                    r_cnt[i] <= 4'd0;
                end else if (w_flip[i]) begin
                    r_buttons[i] <= button_data[i];
                    r_cnt[i]     <= 4'd0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Clear the scanned bit first so a same-cycle flip keeps it pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_push) w_pend_nxt[r_idx] = 1'b0;
        w_pend_nxt = w_pend_nxt | w_flip;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) r_pend <= '0;
        else      r_pend <= w_pend_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = S_SCAN;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_SCAN: begin
                if (r_idx == 4'd11) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 4'd0;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign w_push      = (r_state == S_SCAN) && r_pend[r_idx];
    assign w_push_data = {r_buttons[r_idx], r_idx};

    // A full FIFO still accepts a push when the head is popped the same cycle.
    assign w_pop    = ev_valid & ev_ready;
    assign w_full   = (r_count == FULL_CNT);
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & ~w_accept;

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign ev_valid = (r_count != '0);
    assign ev_data  = ev_valid ? r_mem[r_rd_ptr] : 5'd0;
    assign buttons  = r_buttons;
    assign ev_count = r_count;
    assign overflow = r_ovf;

endmodule
